// File: rtl/pic_pkg.sv
// pic_pkg: shared types and codes for the pic_cmd_sequencer slice.
//   state_t : initialisation sequencer states (S_IDLE .. S_READY)
//   RS_*    : read_sel source codes driven towards the PIC read mux
//   WF_*    : word_flag codes identifying the last committed command word
package pic_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ICW2  = 3'd1,
    S_ICW3  = 3'd2,
    S_ICW4  = 3'd3,
    S_READY = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    RS_NONE = 3'b000,
    RS_IRR  = 3'b001,
    RS_IMR  = 3'b011,
    RS_ISR  = 3'b101,
    RS_POLL = 3'b100
  } rsel_t;

  typedef enum logic [2:0] {
    WF_ICW1 = 3'd0,
    WF_ICW2 = 3'd1,
    WF_ICW3 = 3'd2,
    WF_ICW4 = 3'd3,
    WF_OCW1 = 3'd4,
    WF_OCW2 = 3'd5,
    WF_OCW3 = 3'd6
  } wflag_t;

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// pic_cmd_sequencer_if: CPU-side bus pins of the 8259-style PIC.
//   CS_n, WR_n, RD_n, A0 : chip select, strobes and address (active-low strobes)
//   data_in              : write data, DATA_W bits
//   master modport drives the pins (CPU / bench), slave modport receives them.
// Bus semantics: there is no valid/ready pair. A write cycle is any clock
// where CS_n=0, WR_n=0, RD_n=1 is sampled; it commits on the first clock that
// samples WR_n=1 afterwards. A read cycle is CS_n=0, RD_n=0, WR_n=1. Both
// strobes low together is not a cycle at all. The slave never stalls.
interface pic_cmd_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              CS_n;
  logic              WR_n;
  logic              RD_n;
  logic              A0;
  logic [DATA_W-1:0] data_in;

  modport master (output CS_n, WR_n, RD_n, A0, data_in);
  modport slave  (input  CS_n, WR_n, RD_n, A0, data_in);
endinterface

// File: rtl/pic_bus_strobe.sv
// pic_bus_strobe: turns sampled bus pins into edge-qualified events.
//   clk, rst      : system clock, async active-high reset
//   *_i           : raw CS_n/WR_n/RD_n/A0/data pins
//   commit_o      : high during the clock whose edge commits a write
//   cap_a0_o/cap_data_o : A0/data from the last active write sample
//   rd_act_o      : read cycle active this clock
//   rd_end_o      : first clock sampling RD_n=1 after an active read
module pic_bus_strobe #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n_i,
  input  logic              wr_n_i,
  input  logic              rd_n_i,
  input  logic              a0_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              commit_o,
  output logic              cap_a0_o,
  output logic [DATA_W-1:0] cap_data_o,
  output logic              rd_act_o,
  output logic              rd_end_o
);
  logic              wr_act;
  logic              wr_pend_q;
  logic              rd_pend_q;
  logic              cap_a0_q;
  logic [DATA_W-1:0] cap_data_q;

  assign wr_act   = !cs_n_i && !wr_n_i && rd_n_i;
  assign rd_act_o = !cs_n_i && !rd_n_i && wr_n_i;

  // The pending flag follows only the most recent sample: a low WR_n sample
  // without chip select (or with RD_n also low) cancels an earlier capture.
  assign commit_o   = wr_pend_q && wr_n_i;
  assign rd_end_o   = rd_pend_q && rd_n_i;
  assign cap_a0_o   = cap_a0_q;
  assign cap_data_o = cap_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      cap_a0_q   <= 1'b0;
      cap_data_q <= '0;
    end else begin
      wr_pend_q <= wr_act;
      if (wr_act) begin
        cap_a0_q   <= a0_i;
        cap_data_q <= data_i;
      end
      if (rd_act_o) begin
        rd_pend_q <= 1'b1;
      end else if (rd_n_i) begin
        rd_pend_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: ICW/OCW command-word sequencer for an 8259-style PIC.
//   clk, rst          : system clock, async active-high reset
//   bus               : pic_cmd_sequencer_if.slave (CS_n, WR_n, RD_n, A0, data_in)
//   icw1_q..icw4_q    : stored initialisation words
//   ocw1_q..ocw3_q    : stored operation words (ocw1_q is the IMR)
//   word_flag/word_strb : last committed word code / one-cycle commit pulse
//   read_sel          : registered read-source code (RS_*)
//   init_done, seq_err: READY indicator, sticky sequencing error
//   dbg_state         : current sequencer state
// Build option: define PIC_POLL_EN to enable the OCW3 poll command.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] IMR_RST = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  pic_cmd_sequencer_if.slave bus,
  output logic [DATA_W-1:0] icw1_q,
  output logic [DATA_W-1:0] icw2_q,
  output logic [DATA_W-1:0] icw3_q,
  output logic [DATA_W-1:0] icw4_q,
  output logic [DATA_W-1:0] ocw1_q,
  output logic [DATA_W-1:0] ocw2_q,
  output logic [DATA_W-1:0] ocw3_q,
  output logic [2:0]        word_flag,
  output logic              word_strb,
  output logic [2:0]        read_sel,
  output logic              init_done,
  output logic              seq_err,
  output state_t            dbg_state
);
  logic              commit, cap_a0, rd_act, rd_end;
  logic [DATA_W-1:0] cap_data;
  state_t            state_q, state_d;
  logic              accept, err;
  logic [2:0]        wf;
  logic              rl_isr_q;   // read latch: 0 = IRR, 1 = ISR
  logic              poll_armed;

  pic_bus_strobe #(.DATA_W(DATA_W)) u_strobe (
    .clk        (clk),
    .rst        (rst),
    .cs_n_i     (bus.CS_n),
    .wr_n_i     (bus.WR_n),
    .rd_n_i     (bus.RD_n),
    .a0_i       (bus.A0),
    .data_i     (bus.data_in),
    .commit_o   (commit),
    .cap_a0_o   (cap_a0),
    .cap_data_o (cap_data),
    .rd_act_o   (rd_act),
    .rd_end_o   (rd_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Decode of a committed word. ICW1 wins in every state; everything else
  // depends on where we are in the initialisation sequence.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err     = 1'b0;
    wf      = WF_ICW1;
    if (commit) begin
      if (!cap_a0 && cap_data[4]) begin
        accept  = 1'b1;
        state_d = S_ICW2;
      end else begin
        case (state_q)
          S_IDLE: err = 1'b1;
          S_ICW2: begin
            if (cap_a0) begin
              accept = 1'b1;
              wf     = WF_ICW2;
              if (!icw1_q[1])     state_d = S_ICW3;   // cascade mode
              else if (icw1_q[0]) state_d = S_ICW4;
              else                state_d = S_READY;
            end else err = 1'b1;
          end
          S_ICW3: begin
            if (cap_a0) begin
              accept = 1'b1;
              wf     = WF_ICW3;
              if (icw1_q[0]) state_d = S_ICW4;
              else           state_d = S_READY;
            end else err = 1'b1;
          end
          S_ICW4: begin
            if (cap_a0) begin
              accept  = 1'b1;
              wf      = WF_ICW4;
              state_d = S_READY;
            end else err = 1'b1;
          end
          S_READY: begin
            accept = 1'b1;
            if (cap_a0)           wf = WF_OCW1;
            else if (!cap_data[3]) wf = WF_OCW2;
            else                  wf = WF_OCW3;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icw1_q    <= '0;
      icw2_q    <= '0;
      icw3_q    <= '0;
      icw4_q    <= '0;
      ocw1_q    <= IMR_RST;
      ocw2_q    <= '0;
      ocw3_q    <= '0;
      word_flag <= WF_ICW1;
      word_strb <= 1'b0;
      seq_err   <= 1'b0;
      rl_isr_q  <= 1'b0;
      read_sel  <= RS_NONE;
    end else begin
      word_strb <= accept;
      if (accept) word_flag <= wf;
      if (err)    seq_err   <= 1'b1;
      if (accept) begin
        case (wf)
          WF_ICW1: begin
            icw1_q   <= cap_data;
            icw2_q   <= '0;
            icw3_q   <= '0;
            icw4_q   <= '0;
            ocw1_q   <= IMR_RST;
            rl_isr_q <= 1'b0;
            seq_err  <= 1'b0;
          end
          WF_ICW2: icw2_q <= cap_data;
          WF_ICW3: icw3_q <= cap_data;
          WF_ICW4: icw4_q <= cap_data;
          WF_OCW1: ocw1_q <= cap_data;
          WF_OCW2: ocw2_q <= cap_data;
          WF_OCW3: begin
            ocw3_q <= cap_data;
            if (cap_data[1]) rl_isr_q <= cap_data[0];  // 0x leaves latch alone
          end
          default: ;
        endcase
      end
      if (rd_act) begin
        if (bus.A0)          read_sel <= RS_IMR;
        else if (poll_armed) read_sel <= RS_POLL;
        else if (rl_isr_q)   read_sel <= RS_ISR;
        else                 read_sel <= RS_IRR;
      end else begin
        read_sel <= RS_NONE;
      end
    end
  end

`ifdef PIC_POLL_EN
  logic poll_q, poll_rd_q;   // armed / a poll read has been served

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_q    <= 1'b0;
      poll_rd_q <= 1'b0;
    end else if (accept && wf == WF_ICW1) begin
      poll_q    <= 1'b0;
      poll_rd_q <= 1'b0;
    end else if (accept && wf == WF_OCW3 && cap_data[2]) begin
      poll_q <= 1'b1;
    end else if (rd_act && !bus.A0 && poll_q) begin
      poll_rd_q <= 1'b1;
    end else if (rd_end && poll_rd_q) begin
      poll_q    <= 1'b0;
      poll_rd_q <= 1'b0;
    end
  end

  assign poll_armed = poll_q;
`else
  logic unused_rd_end;
  assign unused_rd_end = rd_end;
  assign poll_armed    = 1'b0;
`endif

  assign init_done = (state_q == S_READY);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
module tb_pic_cmd_sequencer;
  import pic_pkg::*;

  localparam int             DW       = 8;
  localparam logic [DW-1:0]  IMR_INIT = 8'hC3;
`ifdef PIC_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pic_cmd_sequencer_if #(.DATA_W(DW)) bus();

  logic [DW-1:0] icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q, ocw2_q, ocw3_q;
  logic [2:0]    word_flag, read_sel;
  logic          word_strb, init_done, seq_err;
  state_t        dbg_state;

  pic_cmd_sequencer #(.DATA_W(DW), .IMR_RST(IMR_INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .icw1_q    (icw1_q),
    .icw2_q    (icw2_q),
    .icw3_q    (icw3_q),
    .icw4_q    (icw4_q),
    .ocw1_q    (ocw1_q),
    .ocw2_q    (ocw2_q),
    .ocw3_q    (ocw3_q),
    .word_flag (word_flag),
    .word_strb (word_strb),
    .read_sel  (read_sel),
    .init_done (init_done),
    .seq_err   (seq_err),
    .dbg_state (dbg_state)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int n_strb = 0;

  // ---------------- reference model ----------------
  // exp_q lists the ICW indices (1..3) still owed after ICW1.
  logic [DW-1:0] m_icw [4];
  logic [DW-1:0] m_ocw [3];
  logic [2:0]    m_flag;
  bit            m_err, m_isr, m_poll, m_started;
  logic [2:0]    exp_q [$];

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_icw[i] = '0;
    m_ocw[0] = IMR_INIT; m_ocw[1] = '0; m_ocw[2] = '0;
    m_flag = 3'd0; m_err = 0; m_isr = 0; m_poll = 0; m_started = 0;
    exp_q.delete();
  endtask

  task automatic m_write(input bit a0, input logic [DW-1:0] d, output bit acc);
    logic [2:0] k;
    acc = 0;
    if (!a0 && d[4]) begin
      m_icw[0] = d; m_icw[1] = '0; m_icw[2] = '0; m_icw[3] = '0;
      m_ocw[0] = IMR_INIT; m_isr = 0; m_poll = 0; m_err = 0;
      m_flag = 3'd0; m_started = 1; acc = 1;
      exp_q.delete();
      exp_q.push_back(3'd1);
      if (!d[1]) exp_q.push_back(3'd2);
      if (d[0])  exp_q.push_back(3'd3);
    end else if (!m_started) begin
      m_err = 1;
    end else if (exp_q.size() != 0) begin
      if (a0) begin
        k = exp_q.pop_front();
        m_icw[k] = d; m_flag = k; acc = 1;
      end else m_err = 1;
    end else if (a0) begin
      m_ocw[0] = d; m_flag = 3'd4; acc = 1;
    end else if (!d[3]) begin
      m_ocw[1] = d; m_flag = 3'd5; acc = 1;
    end else begin
      m_ocw[2] = d; m_flag = 3'd6; acc = 1;
      if (d[1]) m_isr = d[0];
      if (POLL_EN && d[2]) m_poll = 1;
    end
  endtask

  function automatic state_t m_state();
    if (!m_started) return S_IDLE;
    if (exp_q.size() == 0) return S_READY;
    case (exp_q[0])
      3'd1:    return S_ICW2;
      3'd2:    return S_ICW3;
      default: return S_ICW4;
    endcase
  endfunction

  function automatic logic [2:0] m_sel(input bit a0);
    if (a0)     return 3'b011;
    if (m_poll) return 3'b100;
    return m_isr ? 3'b101 : 3'b001;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string w);
    chk({w, ":icw1"}, 32'(icw1_q), 32'(m_icw[0]));
    chk({w, ":icw2"}, 32'(icw2_q), 32'(m_icw[1]));
    chk({w, ":icw3"}, 32'(icw3_q), 32'(m_icw[2]));
    chk({w, ":icw4"}, 32'(icw4_q), 32'(m_icw[3]));
    chk({w, ":ocw1"}, 32'(ocw1_q), 32'(m_ocw[0]));
    chk({w, ":ocw2"}, 32'(ocw2_q), 32'(m_ocw[1]));
    chk({w, ":ocw3"}, 32'(ocw3_q), 32'(m_ocw[2]));
    chk({w, ":word_flag"}, 32'(word_flag), 32'(m_flag));
    chk({w, ":seq_err"}, 32'(seq_err), 32'(m_err));
    chk({w, ":init_done"}, 32'(init_done), 32'(m_state() == S_READY));
    chk({w, ":state"}, 32'(dbg_state), 32'(m_state()));
    chk({w, ":read_sel_idle"}, 32'(read_sel), 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.CS_n = 1'b1; bus.WR_n = 1'b1; bus.RD_n = 1'b1;
    bus.A0 = 1'b0; bus.data_in = '0;
  endtask

  task automatic do_reset();
    bus_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_reset();
  endtask

  // Holds WR_n low for 1..3 clocks; only the final sample carries a0/d and
  // cs_ok decides whether chip select is active on that final sample.
  task automatic do_write(input bit a0, input logic [DW-1:0] d, input bit cs_ok);
    bit acc;
    int n;
    n = $urandom_range(1, 3);
    bus.RD_n = 1'b1;
    bus.WR_n = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      bus.CS_n = 1'b0;
      bus.A0 = 1'($urandom_range(0, 1));
      bus.data_in = DW'($urandom);
      tick();
    end
    bus.CS_n = !cs_ok; bus.A0 = a0; bus.data_in = d;
    tick();
    bus.WR_n = 1'b1; bus.CS_n = 1'b1;
    bus.A0 = 1'($urandom_range(0, 1)); bus.data_in = DW'($urandom);
    tick();
    acc = 0;
    if (cs_ok) m_write(a0, d, acc);
    if (word_strb) n_strb++;
    chk("word_strb_pulse", 32'(word_strb), 32'(acc));
    check_all("wr");
    tick();
    chk("word_strb_drop", 32'(word_strb), 32'd0);
  endtask

  task automatic do_read(input bit a0, output logic [2:0] seen);
    logic [2:0] e;
    e = m_sel(a0);
    bus.CS_n = 1'b0; bus.RD_n = 1'b0; bus.WR_n = 1'b1; bus.A0 = a0;
    tick();
    seen = read_sel;
    chk("read_sel_active", 32'(read_sel), 32'(e));
    bus.RD_n = 1'b1; bus.CS_n = 1'b1;
    tick();
    if (!a0) m_poll = 0;   // a poll read is consumed when RD_n returns high
    chk("read_sel_after", 32'(read_sel), 32'd0);
  endtask

  task automatic do_clash();
    bus.CS_n = 1'b0; bus.RD_n = 1'b0; bus.WR_n = 1'b0;
    bus.A0 = 1'($urandom_range(0, 1)); bus.data_in = DW'($urandom);
    tick();
    chk("clash_read_sel", 32'(read_sel), 32'd0);
    bus_idle();
    tick();
    tick();
    chk("clash_no_strb", 32'(word_strb), 32'd0);
    check_all("clash");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [2:0] s;
    int op;
    bus_idle();
    m_reset();

    // Reset values
    do_reset();
    check_all("reset");
    chk("reset_ocw1", 32'(ocw1_q), 32'(IMR_INIT));
    chk("reset_strb", 32'(word_strb), 32'd0);

    // Single mode, no ICW4
    do_write(1'b0, 8'h12, 1'b1);
    chk("t1_icw1", 32'(icw1_q), 32'h12);
    chk("t1_flag0", 32'(word_flag), 32'd0);
    chk("t1_state_icw2", 32'(dbg_state), 32'(S_ICW2));
    do_write(1'b1, 8'h40, 1'b1);
    chk("t1_icw2", 32'(icw2_q), 32'h40);
    chk("t1_flag1", 32'(word_flag), 32'd1);
    chk("t1_init_done", 32'(init_done), 32'd1);
    chk("t1_state_ready", 32'(dbg_state), 32'(S_READY));

    // Cascade with ICW4
    do_reset();
    n_strb = 0;
    do_write(1'b0, 8'h11, 1'b1);
    chk("t2_state_icw2", 32'(dbg_state), 32'(S_ICW2));
    do_write(1'b1, 8'h20, 1'b1);
    chk("t2_state_icw3", 32'(dbg_state), 32'(S_ICW3));
    do_write(1'b1, 8'h04, 1'b1);
    chk("t2_state_icw4", 32'(dbg_state), 32'(S_ICW4));
    do_write(1'b1, 8'h01, 1'b1);
    chk("t2_state_ready", 32'(dbg_state), 32'(S_READY));
    chk("t2_icw4", 32'(icw4_q), 32'h01);
    chk("t2_icw3", 32'(icw3_q), 32'h04);
    chk("t2_strobes", 32'(n_strb), 32'd4);

    // Out of order
    do_reset();
    do_write(1'b1, 8'h40, 1'b1);
    chk("t3_seq_err", 32'(seq_err), 32'd1);
    chk("t3_icw2_unchanged", 32'(icw2_q), 32'h00);
    chk("t3_state_idle", 32'(dbg_state), 32'(S_IDLE));
    do_write(1'b0, 8'h13, 1'b1);
    chk("t3_seq_err_clr", 32'(seq_err), 32'd0);
    do_write(1'b0, 8'h02, 1'b1);   // A0=0 non-ICW1 while waiting for ICW2
    chk("t3_err_in_icw2", 32'(seq_err), 32'd1);
    chk("t3_hold_icw2", 32'(dbg_state), 32'(S_ICW2));
    do_write(1'b1, 8'h08, 1'b1);
    do_write(1'b1, 8'h02, 1'b1);
    chk("t3_ready", 32'(init_done), 32'd1);

    // Read select
    do_read(1'b0, s);
    chk("t4_pre_irr", 32'(s), 32'b001);
    do_write(1'b0, 8'h0B, 1'b1);
    chk("t4_flag_ocw3", 32'(word_flag), 32'd6);
    do_read(1'b0, s);
    chk("t4_isr", 32'(s), 32'b101);
    do_read(1'b1, s);
    chk("t4_imr", 32'(s), 32'b011);
    do_write(1'b0, 8'h08, 1'b1);
    do_read(1'b0, s);
    chk("t4_isr_kept", 32'(s), 32'b101);
    do_write(1'b1, 8'h5A, 1'b1);
    chk("t4_ocw1", 32'(ocw1_q), 32'h5A);
    do_write(1'b0, 8'h20, 1'b1);
    chk("t4_ocw2", 32'(ocw2_q), 32'h20);

    // Poll
    do_write(1'b0, 8'h0C, 1'b1);
    do_read(1'b0, s);
    chk("t5_poll_first", 32'(s), POLL_EN ? 32'b100 : 32'b101);
    do_read(1'b0, s);
    chk("t5_poll_after", 32'(s), 32'b101);

    // Mid-init reset during the ICW3 write
    do_reset();
    do_write(1'b0, 8'h11, 1'b1);
    do_write(1'b1, 8'h20, 1'b1);
    bus.CS_n = 1'b0; bus.RD_n = 1'b1; bus.WR_n = 1'b0; bus.A0 = 1'b1; bus.data_in = 8'h04;
    tick();
    rst = 1'b1;
    #1;
    m_reset();
    chk("t6_async_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    rst = 1'b0;
    bus.WR_n = 1'b1; bus.CS_n = 1'b1;
    tick();
    tick();
    chk("t6_no_strb", 32'(word_strb), 32'd0);
    check_all("t6");

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 19);
      if (op < 3) begin
        do_write(1'b0, DW'($urandom) | 8'h10, 1'b1);
      end else if (op < 11) begin
        do_write(1'($urandom_range(0, 1)), DW'($urandom), 1'b1);
      end else if (op < 16) begin
        do_read(1'($urandom_range(0, 1)), s);
      end else if (op < 18) begin
        do_write(1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
      end else if (op < 19) begin
        do_clash();
      end else begin
        do_reset();
        check_all("rand_reset");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
